// File: rtl/rc4_key_search_ctrl.sv
// Top-level sequencer for the RC4 key search. For each candidate key it runs
// the init, shuffle and decrypt engines in turn, granting the shared
// single-port S memory to whichever engine owns the current phase. It stops
// when decrypt reports a valid plaintext or when the last key has been tried.
module rc4_key_search_ctrl #(
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_END   = 24'h3FFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             init_start,
  input  logic             init_fin,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       init_din,
  input  logic             init_wr,
  output logic             shuf_start,
  input  logic             shuf_fin,
  input  logic [7:0]       shuf_addr,
  input  logic [7:0]       shuf_din,
  input  logic             shuf_wr,
  output logic             dec_start,
  input  logic             dec_fin,
  input  logic             dec_valid,
  input  logic [7:0]       dec_addr,
  input  logic [7:0]       dec_din,
  input  logic             dec_wr,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_din,
  output logic             s_wr,
  output logic [KEY_W-1:0] secret_key,
  output logic             busy,
  output logic             done,
  output logic             found
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_GO, S_INIT_RUN, S_SHUF_GO, S_SHUF_RUN,
    S_DEC_GO, S_DEC_RUN, S_NEXT_KEY, S_DONE
  } state_t;

  localparam logic [KEY_W-1:0] KEY_ONE = {{(KEY_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [KEY_W-1:0] key_reg;
  logic             found_reg;
  logic             init_start_reg, shuf_start_reg, dec_start_reg;
  logic             launch;

  // A new search may only begin from the two idle states; start is ignored otherwise.
  assign launch = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  // State register, key counter, result flag and registered start pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      key_reg        <= KEY_START;
      found_reg      <= 1'b0;
      init_start_reg <= 1'b0;
      shuf_start_reg <= 1'b0;
      dec_start_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      init_start_reg <= (state_next == S_INIT_GO);
      shuf_start_reg <= (state_next == S_SHUF_GO);
      dec_start_reg  <= (state_next == S_DEC_GO);
      if (launch) begin
        key_reg   <= KEY_START;
        found_reg <= 1'b0;
      end else if (state_reg == S_NEXT_KEY) begin
        key_reg <= key_reg + KEY_ONE;
      end
      if ((state_reg == S_DEC_RUN) && dec_fin && dec_valid) begin
        found_reg <= 1'b1;
      end
    end
  end

  // Next-state logic; each RUN state only listens to its own engine's finish strobe.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (start) state_next = S_INIT_GO;
      S_INIT_GO:  state_next = S_INIT_RUN;
      S_INIT_RUN: if (init_fin) state_next = S_SHUF_GO;
      S_SHUF_GO:  state_next = S_SHUF_RUN;
      S_SHUF_RUN: if (shuf_fin) state_next = S_DEC_GO;
      S_DEC_GO:   state_next = S_DEC_RUN;
      S_DEC_RUN: begin
        if (dec_fin) begin
          // The last key is never incremented past, so the counter cannot wrap.
          if (dec_valid || (key_reg == KEY_END)) state_next = S_DONE;
          else                                   state_next = S_NEXT_KEY;
        end
      end
      S_NEXT_KEY: state_next = S_INIT_GO;
      S_DONE:     if (start) state_next = S_INIT_GO;
      default:    state_next = S_IDLE;
    endcase
  end

  // Status decode and S-memory port grant; an ungranted engine never reaches the port.
  always_comb begin
    s_addr = 8'h00;
    s_din  = 8'h00;
    s_wr   = 1'b0;
    busy   = (state_reg != S_IDLE) && (state_reg != S_DONE);
    done   = (state_reg == S_DONE);
    case (state_reg)
      S_INIT_GO, S_INIT_RUN: begin
        s_addr = init_addr;
        s_din  = init_din;
        s_wr   = init_wr;
      end
      S_SHUF_GO, S_SHUF_RUN: begin
        s_addr = shuf_addr;
        s_din  = shuf_din;
        s_wr   = shuf_wr;
      end
      S_DEC_GO, S_DEC_RUN: begin
        s_addr = dec_addr;
        s_din  = dec_din;
        s_wr   = dec_wr;
      end
      default: begin
        s_addr = 8'h00;
        s_din  = 8'h00;
        s_wr   = 1'b0;
      end
    endcase
  end

  assign init_start = init_start_reg;
  assign shuf_start = shuf_start_reg;
  assign dec_start  = dec_start_reg;
  assign secret_key = key_reg;
  assign found      = found_reg;

endmodule
